retire_trace_buffer: RTL and testbench
======================================

# retire_trace_buffer

Parametrised retirement-trace capture block for the RISC-V 5-stage pipelined processor. Taps the writeback stage and records each retired instruction (PC, instruction word, destination register, result, cycle stamp) into a circular buffer, drainable through a valid/ready read port. Supports wrap, stop-when-full and PC-triggered capture modes, plus a retirement-limit halt request, replacing per-cycle console dumps with bounded, filterable on-chip capture.

## Interface
- XLEN, 32, width of PC and result fields
- DEPTH, 64, entries in buffer; power of two, >= 4
- CYCLE_W, 32, cycle-stamp width
- RETIRE_LIMIT, 1000, retirements before halt_req; 0 disables
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- retire_valid  in  1  instruction retires in W stage this cycle
- retire_pc  in  XLEN  PC of retiring instruction
- retire_instr  in  32  instruction word
- retire_rd  in  5  destination register
- retire_we  in  1  RegWrite_W of retiring instruction
- retire_data  in  XLEN  result_W
- mode  in  2  0 WRAP, 1 STOP_FULL, 2 TRIGGER, 3 reserved (treated as WRAP)
- arm  in  1  one-cycle pulse: clear buffer, start capture
- stop  in  1  one-cycle pulse: end capture
- trig_pc  in  XLEN  trigger PC (TRIGGER mode)
- post_count  in  $clog2(DEPTH)+1  entries to record after trigger entry
- rd_valid  out  1  buffer non-empty
- rd_ready  in  1  consumer pops head entry
- rd_pc, rd_instr, rd_rd, rd_we, rd_data, rd_cycle  out  matching widths  head entry fields
- count  out  $clog2(DEPTH)+1  occupied entries
- state  out  2  IDLE 0, ARMED 1, CAPTURE 2, DONE 3
- overflow  out  1  sticky: entry overwritten since last arm
- halt_req  out  1  sticky: retirement limit reached

## Operation
- Free-running cycle counter from reset, wraps modulo 2^CYCLE_W; stamp = counter value in the capture cycle.
- arm (any state): head=tail=count=0, overflow=0; next state ARMED if mode==TRIGGER else CAPTURE. mode sampled only at arm.
- stop in ARMED/CAPTURE -> DONE; ignored in IDLE/DONE. arm and stop same cycle: arm wins.
- Records: in ARMED and CAPTURE, each retire_valid writes one entry at tail.
- WRAP: full + write without pop -> overwrite oldest, head advances, overflow=1, count stays DEPTH.
- STOP_FULL: write that makes count==DEPTH -> DONE; no further writes.
- TRIGGER: ARMED wraps as WRAP. Retire with retire_pc==trig_pc in ARMED: entry recorded, post counter loaded with post_count; post_count==0 -> DONE, else CAPTURE. In CAPTURE each record decrements post counter; record bringing it to 0 -> DONE. CAPTURE continues to wrap if full.
- Read: rd_* show head entry combinationally; pop on rd_valid && rd_ready, legal in every state. rd_* undefined (drive 0) when empty.
- Simultaneous write and pop: pop head, write tail; count unchanged; full+simultaneous is not an overwrite (overflow unchanged).
- Retirement counter counts every retire_valid regardless of state, saturates at RETIRE_LIMIT; reaching it sets halt_req.

## Timing
- Reset: state IDLE, count 0, head/tail 0, overflow 0, halt_req 0, cycle counter 0, rd_valid 0, rd_* 0.
- Write latency: entry captured at edge of retire cycle; visible on rd_* (if head) and count the following cycle.
- State transitions take effect at the capturing edge; retire in same cycle as arm is not recorded.
- halt_req rises one cycle after the RETIRE_LIMIT-th retire_valid edge.
- Reset mid-capture: all state lost, returns to IDLE immediately (async).

## Structure
- Package trace_pkg: state encodings, mode encodings, entry field widths and packed entry typedef (XLEN+32+5+1+XLEN+CYCLE_W).
- Sub-module trace_ram: DEPTH x entry, one synchronous write port, one asynchronous read port; no reset on array.
- Top holds FSM, pointers, count, post counter, cycle and retirement counters.

## Test plan
- WRAP, DEPTH=4: arm, 6 retires PC 0x00..0x14 step 4, no reads -> count 4, overflow 1, drain yields PCs 0x08,0x0C,0x10,0x14.
- STOP_FULL, DEPTH=4: arm, 6 retires -> DONE after 4th, drain yields first 4 PCs, overflow 0.
- TRIGGER, trig_pc=0x40, post_count=2: retires 0x30..0x60 step 4 -> DONE after 0x48 recorded; last three drained entries 0x40,0x44,0x48.
- Full buffer with simultaneous retire and pop each cycle for 10 cycles (WRAP) -> count stays 4, overflow 0, drained stream in order with no gap.
- RETIRE_LIMIT=5: 5 retires in IDLE -> halt_req 1 one cycle after 5th, stays 1; count 0.
- Assert rst_n low during CAPTURE with count 3 -> state IDLE, count 0, rd_valid 0, halt_req 0 immediately.

Source files
------------

// File: rtl/retire_trace_buffer_pkg.sv
// Shared definitions for the retirement trace buffer.
//   - FSM state and capture-mode encodings (values are visible on the
//     block's state/mode ports, so they are fixed numbers).
//   - Fixed field widths of a trace entry. The XLEN and CYCLE_W dependent
//     packed entry type is declared in the top, where those parameters live.
//   - entry_width(): total bits of one packed entry, used to size the RAM.
package retire_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_WRAP      = 2'd0,
    MODE_STOP_FULL = 2'd1,
    MODE_TRIGGER   = 2'd2,
    MODE_RSVD      = 2'd3   // behaves exactly like MODE_WRAP
  } trace_mode_e;

  localparam int INSTR_W = 32;
  localparam int RD_W    = 5;

  // pc + instr + rd + we + data + cycle stamp
  function automatic int entry_width(input int xlen, input int cycle_w);
    return xlen + INSTR_W + RD_W + 1 + xlen + cycle_w;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Bus bundle for the retirement trace buffer.
//   retire_* : writeback-stage tap (producer -> buffer), sampled every cycle
//              that retire_valid is high; there is no back-pressure.
//   rd_*     : drain port (buffer -> consumer).
// Handshake: rd_valid is high whenever the buffer holds at least one entry and
// rd_* then show the oldest entry. An entry is consumed on a rising clk edge
// where rd_valid && rd_ready; rd_ready may be held high while rd_valid is low
// (nothing happens). rd_* read as zero while rd_valid is low.
// Modports: master = producer/consumer side, slave = trace buffer.
interface retire_trace_buffer_if
  import retire_trace_buffer_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CYCLE_W = 32
);
  logic               retire_valid;
  logic [XLEN-1:0]    retire_pc;
  logic [INSTR_W-1:0] retire_instr;
  logic [RD_W-1:0]    retire_rd;
  logic               retire_we;
  logic [XLEN-1:0]    retire_data;

  logic               rd_valid;
  logic               rd_ready;
  logic [XLEN-1:0]    rd_pc;
  logic [INSTR_W-1:0] rd_instr;
  logic [RD_W-1:0]    rd_rd;
  logic               rd_we;
  logic [XLEN-1:0]    rd_data;
  logic [CYCLE_W-1:0] rd_cycle;

  modport master (
    output retire_valid, retire_pc, retire_instr, retire_rd, retire_we, retire_data,
    output rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_rd, rd_we, rd_data, rd_cycle
  );

  modport slave (
    input  retire_valid, retire_pc, retire_instr, retire_rd, retire_we, retire_data,
    input  rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_rd, rd_we, rd_data, rd_cycle
  );

endinterface

// File: rtl/retire_trace_buffer_ram.sv
// Entry storage for the trace buffer: DEPTH x W array with one synchronous
// write port and one asynchronous (combinational) read port. The array has
// no reset; validity of its contents is tracked by the pointers in the top.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module retire_trace_buffer_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: records each retiring instruction into a circular
// buffer, drained through the bus rd_* valid/ready port.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   bus (slave)      retire_* tap in, rd_* drain out (see interface header)
//   mode             capture mode, sampled only on arm
//   arm / stop       one-cycle control pulses (arm has priority)
//   trig_pc          trigger PC for TRIGGER mode
//   post_count       entries to record after the trigger entry
//   count            occupied entries
//   state            FSM state (IDLE/ARMED/CAPTURE/DONE)
//   overflow         sticky, an unread entry was overwritten since last arm
//   halt_req         sticky, RETIRE_LIMIT retirements seen (0 disables)
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 64,
  parameter int CYCLE_W      = 32,
  parameter int RETIRE_LIMIT = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  retire_trace_buffer_if.slave     bus,
  input  logic [1:0]               mode,
  input  logic                     arm,
  input  logic                     stop,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic [$clog2(DEPTH):0]   post_count,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     overflow,
  output logic                     halt_req
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (RETIRE_LIMIT < 1) ? 1 : $clog2(RETIRE_LIMIT + 1);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [RD_W-1:0]    rd;
    logic               we;
    logic [XLEN-1:0]    data;
    logic [CYCLE_W-1:0] cyc;
  } entry_t;

  localparam int EW = entry_width(XLEN, CYCLE_W);

  trace_state_e      state_q;
  trace_mode_e       mode_q;
  logic [CW-1:0]     post_q;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [CYCLE_W-1:0] cycle_q;
  logic [RW-1:0]     ret_cnt_q, ret_cnt_d;

  logic   capturing, rec, pop, full, overwrite, rd_valid;
  entry_t wr_entry, rd_entry;
  logic [EW-1:0] rd_raw;

  assign capturing = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  // A retire in the same cycle as arm is dropped: arm clears the buffer.
  assign rec       = bus.retire_valid && capturing && !arm;
  assign rd_valid  = (count_q != '0);
  assign pop       = rd_valid && bus.rd_ready && !arm;
  assign full      = (count_q == CW'(DEPTH));
  // A simultaneous pop frees the slot, so full+pop+write is not an overwrite.
  assign overwrite = rec && full && !pop;

  // ---------------- pointers, count, overflow ----------------
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (arm) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (rec)             tail_d = tail_q + AW'(1);
      if (pop || overwrite) head_d = head_q + AW'(1);
      if (overwrite)       overflow_d = 1'b1;
      if (rec && !pop && !full)  count_d = count_q + CW'(1);
      else if (pop && !rec)      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------- capture FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_WRAP;
      post_q  <= '0;
    end else if (arm) begin
      mode_q  <= trace_mode_e'(mode);
      state_q <= (mode == MODE_TRIGGER) ? ST_ARMED : ST_CAPTURE;
    end else if (stop && capturing) begin
      state_q <= ST_DONE;
    end else if (rec) begin
      case (mode_q)
        MODE_STOP_FULL: begin
          if (count_d == CW'(DEPTH)) state_q <= ST_DONE;
        end
        MODE_TRIGGER: begin
          if (state_q == ST_ARMED) begin
            if (bus.retire_pc == trig_pc) begin
              post_q  <= post_count;
              state_q <= (post_count == '0) ? ST_DONE : ST_CAPTURE;
            end
          end else begin
            // CAPTURE after trigger: this record consumes one post slot.
            post_q <= post_q - CW'(1);
            if (post_q == CW'(1)) state_q <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- cycle and retirement counters ----------------
  always_comb begin
    ret_cnt_d = ret_cnt_q;
    if (bus.retire_valid && (RETIRE_LIMIT != 0) && (ret_cnt_q != RW'(RETIRE_LIMIT)))
      ret_cnt_d = ret_cnt_q + RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      ret_cnt_q <= '0;
    end else begin
      cycle_q   <= cycle_q + CYCLE_W'(1);
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // Counter saturates at the limit, which makes halt_req sticky.
  assign halt_req = (RETIRE_LIMIT != 0) && (ret_cnt_q == RW'(RETIRE_LIMIT));

  // ---------------- storage ----------------
  assign wr_entry = '{pc:    bus.retire_pc,
                      instr: bus.retire_instr,
                      rd:    bus.retire_rd,
                      we:    bus.retire_we,
                      data:  bus.retire_data,
                      cyc:   cycle_q};

  retire_trace_buffer_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (rec),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (rd_raw)
  );

  assign rd_entry     = entry_t'(rd_raw);
  assign bus.rd_valid = rd_valid;
  assign bus.rd_pc    = rd_valid ? rd_entry.pc    : '0;
  assign bus.rd_instr = rd_valid ? rd_entry.instr : '0;
  assign bus.rd_rd    = rd_valid ? rd_entry.rd    : '0;
  assign bus.rd_we    = rd_valid ? rd_entry.we    : 1'b0;
  assign bus.rd_data  = rd_valid ? rd_entry.data  : '0;
  assign bus.rd_cycle = rd_valid ? rd_entry.cyc   : '0;

  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int LIMIT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  retire_trace_buffer_if #(.XLEN(XLEN), .CYCLE_W(32)) bus ();

  logic [1:0]      mode;
  logic            arm, stop;
  logic [XLEN-1:0] trig_pc;
  logic [CW-1:0]   post_count;
  logic [CW-1:0]   count;
  logic [1:0]      state;
  logic            overflow, halt_req;

  retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CYCLE_W(32), .RETIRE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mode       (mode),
    .arm        (arm),
    .stop       (stop),
    .trig_pc    (trig_pc),
    .post_count (post_count),
    .count      (count),
    .state      (state),
    .overflow   (overflow),
    .halt_req   (halt_req)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic [31:0] cyc;
  } ent_t;

  ent_t        mq[$];       // modelled buffer contents, oldest first
  int          m_state, m_mode, m_post, m_ovf, m_ret;
  logic [31:0] m_cycle;
  logic [31:0] exp_q[$];    // directed expected drain PCs

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_mode = 0; m_post = 0; m_ovf = 0; m_ret = 0; m_cycle = 0;
  endtask

  // One clock of the reference behaviour, using the inputs currently driven.
  task automatic model_step();
    bit   cap, rec, pop;
    ent_t e;
    cap = (m_state == 1) || (m_state == 2);
    pop = (mq.size() > 0) && bus.rd_ready;
    if (bus.retire_valid && m_ret < LIMIT) m_ret++;
    if (arm) begin
      mq.delete();
      m_ovf   = 0;
      m_mode  = int'(mode);
      m_state = (mode == 2'd2) ? 1 : 2;
    end else begin
      rec = bus.retire_valid && cap;
      if (pop) void'(mq.pop_front());
      if (rec) begin
        e.pc = bus.retire_pc; e.instr = bus.retire_instr; e.rd = bus.retire_rd;
        e.we = bus.retire_we; e.data = bus.retire_data; e.cyc = m_cycle;
        mq.push_back(e);
        if (mq.size() > DEPTH) begin
          void'(mq.pop_front());
          m_ovf = 1;
        end
      end
      if (stop && cap) m_state = 3;
      else if (rec) begin
        if (m_mode == 1 && mq.size() == DEPTH) m_state = 3;
        else if (m_mode == 2) begin
          if (m_state == 1) begin
            if (bus.retire_pc == trig_pc) begin
              m_post  = int'(post_count);
              m_state = (m_post == 0) ? 3 : 2;
            end
          end else begin
            m_post--;
            if (m_post == 0) m_state = 3;
          end
        end
      end
    end
    m_cycle++;
  endtask

  task automatic check_outputs();
    check("state", state, m_state);
    check("count", count, mq.size());
    check("overflow", overflow, m_ovf);
    check("halt_req", halt_req, (m_ret >= LIMIT));
    check("rd_valid", bus.rd_valid, (mq.size() > 0));
    if (mq.size() > 0) begin
      check("rd_pc", bus.rd_pc, mq[0].pc);
      check("rd_instr", bus.rd_instr, mq[0].instr);
      check("rd_rd", bus.rd_rd, mq[0].rd);
      check("rd_we", bus.rd_we, mq[0].we);
      check("rd_data", bus.rd_data, mq[0].data);
      check("rd_cycle", bus.rd_cycle, mq[0].cyc);
    end else begin
      check("rd_pc_empty", bus.rd_pc, 0);
      check("rd_data_empty", bus.rd_data, 0);
      check("rd_cycle_empty", bus.rd_cycle, 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.retire_valid = 1'b0;
    bus.rd_ready     = 1'b0;
    arm  = 1'b0;
    stop = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_retire(input logic [31:0] pc);
    bus.retire_valid = 1'b1;
    bus.retire_pc    = pc;
    bus.retire_instr = $urandom;
    bus.retire_rd    = 5'($urandom_range(0, 31));
    bus.retire_we    = 1'($urandom_range(0, 1));
    bus.retire_data  = $urandom;
  endtask

  task automatic do_arm(input logic [1:0] md);
    idle_inputs();
    mode = md;
    arm  = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();
  endtask

  task automatic drain_expected();
    idle_inputs();
    while (exp_q.size() > 0) begin
      check("drain_pc", bus.rd_pc, exp_q.pop_front());
      bus.rd_ready = 1'b1;
      tick();
    end
    bus.rd_ready = 1'b0;
    check("drained_count", count, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    mode = 2'd0; trig_pc = '0; post_count = '0;
    bus.retire_pc = '0; bus.retire_instr = '0; bus.retire_rd = '0;
    bus.retire_we = 1'b0; bus.retire_data = '0;
    model_reset();

    // Reset state
    do_reset();
    check("reset_state", state, 0);
    check("reset_count", count, 0);
    check("reset_halt", halt_req, 0);

    // Retirement limit while IDLE
    for (int i = 0; i < 5; i++) begin
      set_retire(32'h200 + 32'(i * 4));
      tick();
      check("halt_after_retire", halt_req, (i == 4));
    end
    idle_inputs();
    tick();
    check("halt_sticky", halt_req, 1);
    check("idle_count", count, 0);

    // WRAP: 6 retires into 4 entries
    do_reset();
    do_arm(2'd0);
    for (int i = 0; i < 6; i++) begin
      set_retire(32'(i * 4));
      tick();
    end
    idle_inputs();
    check("wrap_count", count, 4);
    check("wrap_overflow", overflow, 1);
    exp_q = '{32'h08, 32'h0C, 32'h10, 32'h14};
    drain_expected();

    // STOP_FULL
    do_arm(2'd1);
    for (int i = 0; i < 6; i++) begin
      set_retire(32'(i * 4));
      tick();
      if (i == 3) check("stopfull_done", state, 3);
    end
    idle_inputs();
    check("stopfull_overflow", overflow, 0);
    exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C};
    drain_expected();

    // TRIGGER at 0x40, post_count 2
    trig_pc = 32'h40;
    post_count = 3'd2;
    do_arm(2'd2);
    for (int pc = 'h30; pc <= 'h60; pc += 4) begin
      set_retire(32'(pc));
      tick();
      if (pc == 'h48) check("trig_done", state, 3);
    end
    idle_inputs();
    exp_q = '{32'h3C, 32'h40, 32'h44, 32'h48};
    drain_expected();

    // Full buffer with simultaneous retire and pop every cycle
    do_arm(2'd0);
    for (int i = 0; i < 4; i++) begin
      set_retire(32'(i * 4));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      check("stream_pc", bus.rd_pc, 32'(i * 4));
      set_retire(32'h10 + 32'(i * 4));
      bus.rd_ready = 1'b1;
      tick();
      check("stream_count", count, 4);
    end
    idle_inputs();
    check("stream_overflow", overflow, 0);

    // Randomized phase against the model
    for (int n = 0; n < 500; n++) begin
      idle_inputs();
      if ($urandom_range(0, 29) == 0 || (m_state == 3 && $urandom_range(0, 3) == 0)) begin
        arm        = 1'b1;
        mode       = 2'($urandom_range(0, 3));
        trig_pc    = 32'h100 + 32'($urandom_range(0, 7) * 4);
        post_count = 3'($urandom_range(0, 4));
      end
      stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) != 0) set_retire(32'h100 + 32'($urandom_range(0, 7) * 4));
      bus.rd_ready = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Asynchronous reset in the middle of a capture
    do_arm(2'd0);
    for (int i = 0; i < 3; i++) begin
      set_retire(32'h300 + 32'(i * 4));
      tick();
    end
    idle_inputs();
    check("pre_reset_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_count", count, 0);
    check("async_rst_rd_valid", bus.rd_valid, 0);
    check("async_rst_halt", halt_req, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
